// File: rtl/posit_decode_pipe_pkg.sv
// Shared types and helpers for the pipelined posit decoder.
// Holds sign/class enums, mantissa width helper, bit-count and negate helpers.
package posit_decode_pipe_pkg;

    typedef enum logic {
        POS = 1'b0,
        NEG = 1'b1
    } sign_t;

    // ZERO encodes as 0 so a cleared output register reads as class ZERO.
    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        NORMAL = 2'd1,
        NAR    = 2'd2
    } posit_class_t;

    function automatic int posit_mant_w(input int width);
        return width - 2;
    endfunction

    // Leading zeros within the low n bits of v, scanned MSB-first.
    function automatic logic [4:0] count_lead_zero(
        input logic [15:0] v,
        input int          n
    );
        logic [4:0] c;
        logic       stop;
        c    = '0;
        stop = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (i < n && !stop) begin
                if (v[i]) stop = 1'b1;
                else      c    = c + 5'd1;
            end
        end
        return c;
    endfunction

    function automatic logic [4:0] count_lead_one(
        input logic [15:0] v,
        input int          n
    );
        return count_lead_zero(~v, n);
    endfunction

    function automatic logic [15:0] two_comp(input logic [15:0] v);
        return ~v + 16'd1;
    endfunction

endpackage

// File: rtl/posit_decode_pipe_if.sv
// Stream bundle for the posit decoder: input posit and decoded fields.
// master = producer/consumer side, slave = decoder; out_scale with POSIT_DEC_SCALE_EN.
interface posit_decode_pipe_if #(
    parameter int WIDTH = 8,
    parameter int ES    = 1,
    parameter int REG_W = 8
);
    localparam int MANT_W = posit_decode_pipe_pkg::posit_mant_w(WIDTH);
    localparam int EW     = (ES > 0) ? ES : 1;

    logic                               in_valid;
    logic                               in_ready;
    logic [WIDTH-1:0]                   in_posit;
    logic                               out_valid;
    logic                               out_ready;
    posit_decode_pipe_pkg::sign_t        out_sign;
    posit_decode_pipe_pkg::posit_class_t out_class;
    logic signed [REG_W-1:0]            out_regime;
    logic [EW-1:0]                      out_exponent;
    logic [MANT_W-1:0]                  out_mantissa;
`ifdef POSIT_DEC_SCALE_EN
    logic signed [REG_W+ES-1:0]         out_scale;
`endif

    modport master (
        output in_valid, in_posit, out_ready,
        input  in_ready, out_valid, out_sign, out_class,
        input  out_regime, out_exponent, out_mantissa
`ifdef POSIT_DEC_SCALE_EN
        , input out_scale
`endif
    );

    modport slave (
        input  in_valid, in_posit, out_ready,
        output in_ready, out_valid, out_sign, out_class,
        output out_regime, out_exponent, out_mantissa
`ifdef POSIT_DEC_SCALE_EN
        , output out_scale
`endif
    );

endinterface

// File: rtl/posit_decode_pipe_field_split.sv
// Combinational split of an absolute posit body into regime/exponent/mantissa.
// In: body_i. Out: regime_o (signed), exp_o (right-aligned), mant_o (hidden 1 at MSB).
module posit_field_split
    import posit_decode_pipe_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int ES     = 1,
    parameter  int REG_W  = 8,
    localparam int BW     = WIDTH - 1,
    localparam int MANT_W = posit_mant_w(WIDTH),
    localparam int EW     = (ES > 0) ? ES : 1
) (
    input  logic [BW-1:0]           body_i,
    output logic signed [REG_W-1:0] regime_o,
    output logic [EW-1:0]           exp_o,
    output logic [MANT_W-1:0]       mant_o
);
    logic [15:0]      ext;
    logic             lead;
    logic [4:0]       run;
    logic [5:0]       sh;
    logic [BW-1:0]    rest;
    logic [BW-1:0]    frac;
    logic [REG_W-1:0] run_w;

    always_comb begin
        ext   = 16'(body_i);
        lead  = body_i[BW-1];
        run   = lead ? count_lead_one(ext, BW) : count_lead_zero(ext, BW);
        // drop the run and its terminator; shifting past the LSB fills zeros
        sh    = {1'b0, run} + 6'd1;
        rest  = body_i << sh;
        frac  = rest << ES;
        run_w = REG_W'(run);
        regime_o = lead ? run_w - REG_W'(1) : REG_W'(0) - run_w;
        mant_o   = {1'b1, frac[BW-1 -: MANT_W-1]};
    end

    if (ES > 0) begin : g_exp
        assign exp_o = rest[BW-1 -: EW];
    end else begin : g_noexp
        assign exp_o = '0;
    end

endmodule

// File: rtl/posit_decode_pipe.sv
// Two-stage posit decoder: S1 registers sign/class/abs body, S2 the fields.
// Ports: clk, rst_n (sync, active-low), bus (slave); POSIT_DEC_SCALE_EN adds out_scale.
module posit_decode_pipe
    import posit_decode_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ES    = 1,
    parameter int REG_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    posit_decode_pipe_if.slave bus
);
    localparam int BW     = WIDTH - 1;
    localparam int MANT_W = posit_mant_w(WIDTH);
    localparam int EW     = (ES > 0) ? ES : 1;
    localparam logic [WIDTH-1:0] NAR_PAT = {1'b1, {(WIDTH-1){1'b0}}};

    logic               s1_valid_q, s1_valid_d;
    sign_t              s1_sign_q, s1_sign_d;
    posit_class_t       s1_class_q, s1_class_d;
    logic [BW-1:0]      s1_body_q, s1_body_d;

    logic               s2_valid_q, s2_valid_d;
    sign_t              s2_sign_q, s2_sign_d;
    posit_class_t       s2_class_q, s2_class_d;
    logic [REG_W-1:0]   s2_reg_q, s2_reg_d;
    logic [EW-1:0]      s2_exp_q, s2_exp_d;
    logic [MANT_W-1:0]  s2_mant_q, s2_mant_d;

    logic               s2_adv;
    logic               in_rdy;
    logic               accept;
    logic [15:0]        neg16;
    logic signed [REG_W-1:0] f_reg;
    logic [EW-1:0]      f_exp;
    logic [MANT_W-1:0]  f_mant;
    logic               f_norm;

    assign s2_adv = bus.out_ready | ~s2_valid_q;
    assign in_rdy = ~s1_valid_q | s2_adv;
    assign accept = bus.in_valid & in_rdy;
    assign neg16  = two_comp(16'(bus.in_posit));

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_class_d = s1_class_q;
        s1_body_d  = s1_body_q;
        if (in_rdy) s1_valid_d = bus.in_valid;
        if (accept) begin
            s1_sign_d = sign_t'(bus.in_posit[WIDTH-1]);
            unique case (1'b1)
                (bus.in_posit == '0):     s1_class_d = ZERO;
                (bus.in_posit == NAR_PAT): s1_class_d = NAR;
                default:                  s1_class_d = NORMAL;
            endcase
            s1_body_d = bus.in_posit[WIDTH-1] ? neg16[BW-1:0]
                                              : bus.in_posit[BW-1:0];
        end
    end

    posit_field_split #(
        .WIDTH (WIDTH),
        .ES    (ES),
        .REG_W (REG_W)
    ) u_split (
        .body_i   (s1_body_q),
        .regime_o (f_reg),
        .exp_o    (f_exp),
        .mant_o   (f_mant)
    );

    assign f_norm = (s1_class_q == NORMAL);

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_class_d = s2_class_q;
        s2_reg_d   = s2_reg_q;
        s2_exp_d   = s2_exp_q;
        s2_mant_d  = s2_mant_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sign_d  = s1_sign_q;
                s2_class_d = s1_class_q;
                s2_reg_d   = f_norm ? f_reg : '0;
                s2_exp_d   = f_norm ? f_exp : '0;
                s2_mant_d  = f_norm ? f_mant : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= POS;
            s1_class_q <= ZERO;
            s1_body_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_sign_q  <= POS;
            s2_class_q <= ZERO;
            s2_reg_q   <= '0;
            s2_exp_q   <= '0;
            s2_mant_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_class_q <= s1_class_d;
            s1_body_q  <= s1_body_d;
            s2_valid_q <= s2_valid_d;
            s2_sign_q  <= s2_sign_d;
            s2_class_q <= s2_class_d;
            s2_reg_q   <= s2_reg_d;
            s2_exp_q   <= s2_exp_d;
            s2_mant_q  <= s2_mant_d;
        end
    end

    assign bus.in_ready     = in_rdy;
    assign bus.out_valid    = s2_valid_q;
    assign bus.out_sign     = s2_sign_q;
    assign bus.out_class    = s2_class_q;
    assign bus.out_regime   = s2_reg_q;
    assign bus.out_exponent = s2_exp_q;
    assign bus.out_mantissa = s2_mant_q;

`ifdef POSIT_DEC_SCALE_EN
    localparam int SW = REG_W + ES;
    logic signed [SW-1:0] scale_q, scale_d;

    always_comb begin
        scale_d = scale_q;
        if (s2_adv && s1_valid_q) begin
            scale_d = f_norm ? (SW'(f_reg) <<< ES) + SW'(f_exp) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) scale_q <= '0;
        else        scale_q <= scale_d;
    end

    assign bus.out_scale = scale_q;
`endif

endmodule
